// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic stage register, main + skid entries, valid/ready.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble/flush performance counters.
module pipe_stage_elastic #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 128
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_stall,
   output logic [CNT_W-1:0]  perf_bubble,
   output logic [CNT_W-1:0]  perf_flush
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              push;
   logic              pop;

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready;

   // Occupancy FSM; main register drives out_* directly, zeroed whenever empty.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
         out_ctrl  <= '0;
         out_data  <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
         out_ctrl  <= '0;
         out_data  <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
                  occupancy <= 2'd1;
                  out_ctrl  <= in_ctrl;
                  out_data  <= in_data;
               end
            end
            ONE: begin
               if (push && pop) begin
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end else if (push) begin
                  state     <= FULL;
                  in_ready  <= 1'b0;
                  occupancy <= 2'd2;
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
               end else if (pop) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  occupancy <= 2'd0;
                  out_ctrl  <= '0;
                  out_data  <= '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  occupancy <= 2'd1;
                  out_ctrl  <= skid_ctrl;
                  out_data  <= skid_data;
                  skid_ctrl <= '0;
                  skid_data <= '0;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               occupancy <= 2'd0;
               out_ctrl  <= '0;
               out_data  <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic flush_hit;

   // A flush only counts when it actually throws something away.
   assign flush_hit = flush & ((state != EMPTY) | in_valid);

   // Saturating event counters sampled once per cycle.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         perf_stall  <= '0;
         perf_bubble <= '0;
         perf_flush  <= '0;
      end else begin
         if (out_valid && !out_ready && perf_stall != '1)
            perf_stall <= perf_stall + 1'b1;
         if (!out_valid && perf_bubble != '1)
            perf_bubble <= perf_bubble + 1'b1;
         if (flush_hit && perf_flush != '1)
            perf_flush <= perf_flush + 1'b1;
      end
   end
`endif

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generic elastic pipeline stage register for the pipelined core, with one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle under a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput under backpressure.
- Supports synchronous flush (bubble insertion) and generates NOP-clean control when empty.

Parameters:
- CTRL_W, 16: width of the control bundle (RegWrite, MemWrite, ALUControl, cond, and similar fields); zeroed on every bubble.
- DATA_W, 128: width of the data bundle (operands, immediate, register addresses).
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush; drops every stored entry and the incoming beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  main entry control; all zeros when out_valid=0.
- out_data  out  DATA_W  main entry data; all zeros when out_valid=0.
- occupancy  out  2  number of stored entries: 0, 1 or 2.

Behaviour:
- Storage consists of a main register (drives the outputs) and a skid register. States: EMPTY (0 entries), ONE (main only), FULL (main and skid).
- Reset: CLR=1 forces EMPTY immediately, regardless of CLK. Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, both registers zero.
- Handshake definitions: push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- Latency: 1 cycle. A beat pushed at edge N appears on out_* after edge N when the stage was EMPTY, or when it was ONE with a pop in the same cycle.
- EMPTY:
  - push → ONE; main ← in.
  - no push → stay EMPTY.
- ONE:
  - push & pop → ONE; main ← in.
  - push & !pop → FULL; skid ← in.
  - !push & pop → EMPTY; main cleared to zero.
  - neither → hold.
- FULL (in_ready=0, so push is impossible):
  - pop → ONE; main ← skid, skid cleared.
  - no pop → hold. Data must stay stable while out_valid & !out_ready.
- Flush:
  - flush=1 at an edge → EMPTY from any state; both registers zeroed.
  - The incoming beat is dropped even if in_valid=1.
  - A simultaneous pop still completes downstream on that cycle (the beat leaves before clearing).
  - in_ready returns to 1 after the flush edge.
- Upstream rule: in_valid must not depend on in_ready. Beats with in_valid=1 and in_ready=0 are not consumed; upstream holds them.
- Ordering: strictly FIFO. The skid entry never overtakes the main entry.
- No combinational path from out_ready to in_ready. All outputs come straight from registers.
- CLR asserted mid-transfer discards all entries. No partial beat is ever presented after CLR deasserts.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, the block adds three output ports, each CNT_W wide, saturating at all-ones and cleared by CLR:
  - perf_stall: increments each cycle with out_valid & !out_ready.
  - perf_bubble: increments each cycle with out_valid=0.
  - perf_flush: increments on each flush edge that discards at least one stored entry or an incoming valid beat.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold CLR=1 mid-cycle with the stage FULL → outputs go 0 immediately, in_ready=1, occupancy=0. A push of ctrl=0x0005 on the first edge after release → out_ctrl=0x0005 one cycle later.
- Streaming: out_ready=1, push ctrl 1..8 on consecutive cycles → out_ctrl shows 1..8 on consecutive cycles, in order; in_ready stays 1; occupancy never exceeds 1.
- Backpressure: out_ready=0, push A then B → occupancy=2 and in_ready=0 after the second edge; out_ctrl=A held stable. Raise out_ready for two cycles → A then B delivered, in_ready=1 again.
- Flush: FULL with A,B, then flush=1 with in_valid=1 carrying C → next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears.
- Flush with pop: ONE with A, out_ready=1, flush=1 → A counted as delivered on that edge; stage EMPTY afterwards.
- Counters (PIPE_STAGE_PERF_EN, CNT_W=4):
  - Stall 20 cycles → perf_stall saturates at 15.
  - 3 flushes while non-empty → perf_flush=3.
  - 1 flush while EMPTY with in_valid=0 → perf_flush unchanged.
